cpuc_program_loader: RTL

//  Upstream feeder of the cpuc instruction memory. Receives a program as a stream of DATA_WIDTH-bit

---
 rtl/cpuc_program_loader.sv | 105 ++++++++++
 1 files changed

// File: rtl/cpuc_program_loader.sv
// Streams a program into cpuc instruction memory, one packed instruction per
// write, and holds the core in reset until the whole program has been written.
module cpuc_program_loader #(
    parameter int DATA_WIDTH   = 32,
    parameter int INST_LENGTH  = 248,
    parameter int PROGRAM_SIZE = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            in_valid,
    input  logic [DATA_WIDTH-1:0]           in_data,
    output logic                            in_ready,
    output logic [INST_LENGTH-1:0]          instruction,
    output logic                            wren,
    output logic [$clog2(PROGRAM_SIZE)-1:0] inst_addr,
    output logic                            core_rst,
    output logic                            busy,
    output logic                            done
);

    localparam int CHUNKS = (INST_LENGTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int AW     = $clog2(PROGRAM_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        RUN
    } state_t;

    state_t                 state;
    logic [CW-1:0]          count;
    logic [INST_LENGTH-1:0] inst_next;
    logic                   xfer;

    assign xfer = in_valid & in_ready;

    // Word k lands at bit k*DATA_WIDTH; bits past INST_LENGTH are dropped.
    always_comb begin
        inst_next = (count == '0) ? '0 : instruction;
        for (int i = 0; i < INST_LENGTH; i++) begin
            if (i / DATA_WIDTH == int'(count)) begin
                inst_next[i] = in_data[i % DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            in_ready    <= 1'b0;
            wren        <= 1'b0;
            inst_addr   <= '0;
            instruction <= '0;
            core_rst    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            unique case (state)
                IDLE, RUN: begin
                    if (start) begin
                        state     <= LOAD;
                        count     <= '0;
                        inst_addr <= '0;
                        in_ready  <= 1'b1;
                        core_rst  <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        instruction <= inst_next;
                        if (count == CW'(CHUNKS - 1)) begin
                            count    <= '0;
                            in_ready <= 1'b0;
                            wren     <= 1'b1;
                            state    <= WRITE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    wren <= 1'b0;
                    if (inst_addr == AW'(PROGRAM_SIZE - 1)) begin
                        state    <= RUN;
                        core_rst <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        inst_addr <= inst_addr + 1'b1;
                        in_ready  <= 1'b1;
                        state     <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
